// File: rtl/sub4_serial.sv
// sub4_serial: bit-serial 4-bit subtractor (optional add mode with SUB4_ADDSUB_EN); ports clk, rst, start, a, b, bi, [mode], d, bo, busy, done
module sub4_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
`ifdef SUB4_ADDSUB_EN
  input  logic       mode,
`endif
  output logic [3:0] d,
  output logic       bo,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [3:0] ra, rb;
  logic [1:0] cnt;
  logic br, mr, mode_in, di, bn;
`ifdef SUB4_ADDSUB_EN
  assign mode_in = mode;
`else
  assign mode_in = 1'b1;
`endif
  // ra doubles as the result register: difference bits shift in from the top
  assign di = ra[0] ^ rb[0] ^ br;
  assign bn = mr ? ((~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br))
                 : ((ra[0] & rb[0]) | ((ra[0] ^ rb[0]) & br));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      mr    <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          br    <= bi;
          mr    <= mode_in;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          ra  <= {di, ra[3:1]};
          rb  <= {1'b0, rb[3:1]};
          br  <= bn;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            d     <= {di, ra[3:1]};
            bo    <= bn;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub4_serial.sv
// tb_sub4_serial: directed self-checking bench for sub4_serial
module tb_sub4_serial;
  logic clk = 1'b0;
  logic rst, start, bi, bo, busy, done, mode;
  logic [3:0] a, b, d;
  int checks = 0;
  int errors = 0;
  logic [3:0] prev_d;
  logic prev_bo;
  always #5 clk = ~clk;
  sub4_serial dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
`ifdef SUB4_ADDSUB_EN
    .mode(mode),
`endif
    .d(d), .bo(bo), .busy(busy), .done(done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_, input logic tbi,
                        input logic [3:0] ed, input logic eb);
    a = ta; b = tb_; bi = tbi; start = 1'b1;
    step();
    start = 1'b0;
    a = ~ta; b = ~tb_; bi = ~tbi;
    chk({tag, "_busy_acc"}, busy, 1);
    chk({tag, "_done_acc"}, done, 0);
    step(); step(); step();
    chk({tag, "_done_early"}, done, 0);
    chk({tag, "_d_hold"}, d, prev_d);
    chk({tag, "_bo_hold"}, bo, prev_bo);
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_d"}, d, ed);
    chk({tag, "_bo"}, bo, eb);
    chk({tag, "_busy_done"}, busy, 1);
    step();
    chk({tag, "_done_end"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_d_keep"}, d, ed);
    prev_d = ed;
    prev_bo = eb;
  endtask
  initial begin
    int np, first, last;
    logic [3:0] cd;
    logic cb;
    rst = 1'b1; start = 1'b1; a = 4'd7; b = 4'd3; bi = 1'b0; mode = 1'b1;
    step(); step();
    chk("rst_d", d, 0);
    chk("rst_bo", bo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; start = 1'b0;
    prev_d = 4'd0; prev_bo = 1'b0;
    step();
    run_op("s7m3", 4'd7, 4'd3, 1'b0, 4'd4, 1'b0);
    run_op("s3m7", 4'd3, 4'd7, 1'b0, 4'd12, 1'b1);
    run_op("s0m0b1", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
    run_op("s15m0", 4'd15, 4'd0, 1'b0, 4'd15, 1'b0);
    run_op("s0m15b1", 4'd0, 4'd15, 1'b1, 4'd0, 1'b1);
    // start re-pulsed while running must be ignored
    a = 4'd10; b = 4'd4; bi = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    np = 0; cd = 4'hx; cb = 1'bx;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) begin np++; cd = d; cb = bo; end
    end
    chk("ign_pulses", np, 1);
    chk("ign_d", cd, 4'd6);
    chk("ign_bo", cb, 0);
    chk("ign_busy", busy, 0);
    // reset at the second RUN cycle aborts the operation
    a = 4'd5; b = 4'd2; bi = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_d", d, 0);
    chk("abort_bo", bo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    np = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) np++;
    end
    chk("abort_nodone", np, 0);
    prev_d = 4'd0; prev_bo = 1'b0;
    run_op("s5m2", 4'd5, 4'd2, 1'b0, 4'd3, 1'b0);
    // start held high: one result every 6 cycles
    a = 4'd9; b = 4'd4; bi = 1'b0; start = 1'b1;
    np = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 11) start = 1'b0;
      if (done) begin
        np++;
        if (first < 0) first = i;
        last = i;
        chk("b2b_d", d, 4'd5);
        chk("b2b_bo", bo, 0);
      end
    end
    chk("b2b_pulses", np, 2);
    chk("b2b_first", first, 4);
    chk("b2b_gap", last - first, 6);
    prev_d = 4'd5; prev_bo = 1'b0;
`ifdef SUB4_ADDSUB_EN
    mode = 1'b0;
    run_op("add9p8c1", 4'd9, 4'd8, 1'b1, 4'd2, 1'b1);
    mode = 1'b1;
    run_op("sub9m8b1", 4'd9, 4'd8, 1'b1, 4'd0, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
